// File: rtl/clock_pkg.sv
// Shared types and constants for the multi-alarm BCD clock.
// Purpose: channel state enum, BCD digit limits, HH:MM and HH:MM:SS packed
//          structs, plus small helpers for load validation and hour decoding.
package clock_pkg;

    typedef enum logic [1:0] {
        StOff,
        StArmed,
        StRinging,
        StSnoozed
    } chan_state_e;

    localparam logic [3:0] DigitMax        = 4'd9;  // units digit of any field
    localparam logic [2:0] Tens60Max       = 3'd5;  // tens digit of minutes/seconds
    localparam logic [1:0] HourTensMax     = 2'd2;
    localparam logic [3:0] HourUnitsMaxAt2 = 4'd3;  // 20..23 only

    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [2:0] m1;
        logic [3:0] m0;
    } hhmm_t;

    typedef struct packed {
        hhmm_t      hm;
        logic [2:0] s1;
        logic [3:0] s0;
    } tod_t;

    // Rejects any digit above 9, minutes above 59 and hours above 23
    // (which also covers a tens-of-hours digit of 3).
    function automatic logic hhmm_valid(hhmm_t t);
        logic hour_ok;
        hour_ok = (t.h1 < HourTensMax) ||
                  ((t.h1 == HourTensMax) && (t.h0 <= HourUnitsMaxAt2));
        return hour_ok && (t.h0 <= DigitMax) && (t.m1 <= Tens60Max) && (t.m0 <= DigitMax);
    endfunction

    function automatic logic [4:0] hour_bin(logic [1:0] h1, logic [3:0] h0);
        return ({3'b000, h1} * 5'd10) + {1'b0, h0};
    endfunction

endpackage

// File: rtl/multi_alarm_clock_if.sv
// Control/display bundle of the multi-alarm clock.
// master: drives BCD load value, load strobes, channel select, alarm controls
//         and display mode; observes display digits, pm, alarm status, load_err.
// slave:  the clock itself (opposite directions).
// NUM_ALARMS must match the value given to the clock instance.
interface multi_alarm_clock_if #(
    parameter int unsigned NUM_ALARMS = 4
);
    localparam int unsigned IdW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

    logic [1:0]            h_in1;
    logic [3:0]            h_in0;
    logic [2:0]            m_in1;
    logic [3:0]            m_in0;
    logic                  ld_time;
    logic                  ld_alarm;
    logic [IdW-1:0]        al_sel;
    logic                  al_en_in;
    logic                  stop_al;
    logic                  snooze;
    logic                  mode_12h;

    logic [1:0]            h_out1;
    logic [3:0]            h_out0;
    logic [2:0]            m_out1;
    logic [3:0]            m_out0;
    logic [2:0]            s_out1;
    logic [3:0]            s_out0;
    logic                  pm;
    logic                  alarm;
    logic [IdW-1:0]        alarm_id;
    logic [NUM_ALARMS-1:0] ring_vec;
    logic                  load_err;

    modport master (
        output h_in1, h_in0, m_in1, m_in0, ld_time, ld_alarm, al_sel, al_en_in,
               stop_al, snooze, mode_12h,
        input  h_out1, h_out0, m_out1, m_out0, s_out1, s_out0, pm, alarm, alarm_id,
               ring_vec, load_err
    );

    modport slave (
        input  h_in1, h_in0, m_in1, m_in0, ld_time, ld_alarm, al_sel, al_en_in,
               stop_al, snooze, mode_12h,
        output h_out1, h_out0, m_out1, m_out0, s_out1, s_out0, pm, alarm, alarm_id,
               ring_vec, load_err
    );

endinterface

// File: rtl/alarm_channel.sv
// One alarm channel: HH:MM register, OFF/ARMED/RINGING/SNOOZED FSM and a
// shared ring/snooze down-counter.
// Ports:
//   clk_1s, reset   1 Hz clock, async active-high reset
//   next_time       time value the clock registers will hold after this edge
//   tick_valid      low when a time load is in progress (no match allowed)
//   stop_al, snooze global silence / snooze controls
//   ld              validated alarm load strobe for this channel
//   al_time_in      HH:MM written by ld
//   al_en_in        enable written by ld (1: ARMED, 0: OFF)
//   ringing         registered ringing flag
module alarm_channel
    import clock_pkg::*;
#(
    parameter int unsigned SNOOZE_S       = 300,
    parameter int unsigned RING_TIMEOUT_S = 60
) (
    input  logic  clk_1s,
    input  logic  reset,
    input  tod_t  next_time,
    input  logic  tick_valid,
    input  logic  stop_al,
    input  logic  snooze,
    input  logic  ld,
    input  hhmm_t al_time_in,
    input  logic  al_en_in,
    output logic  ringing
);

    localparam int unsigned MaxS = (SNOOZE_S > RING_TIMEOUT_S) ? SNOOZE_S : RING_TIMEOUT_S;
    localparam int unsigned CntW = $clog2(MaxS + 1);
    localparam logic [CntW-1:0] RingLoad   = CntW'(RING_TIMEOUT_S);
    localparam logic [CntW-1:0] SnoozeLoad = CntW'(SNOOZE_S);
    localparam logic [CntW-1:0] CntOne     = CntW'(1);

    chan_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    hhmm_t           al_time_q, al_time_d;
    logic            match;

    // State register
    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset) begin
            state_q   <= StOff;
            cnt_q     <= '0;
            al_time_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            al_time_q <= al_time_d;
        end
    end

    assign match = tick_valid && (next_time.hm == al_time_q) &&
                   (next_time.s1 == 3'd0) && (next_time.s0 == 4'd0);

    // Next state. The counter was loaded on the entry edge, so leaving when it
    // holds 1 gives exactly RING_TIMEOUT_S / SNOOZE_S cycles in the state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        al_time_d = al_time_q;
        if (ld) begin
            al_time_d = al_time_in;
            state_d   = al_en_in ? StArmed : StOff;
            cnt_d     = '0;
        end else begin
            case (state_q)
                StOff: begin
                    state_d = StOff;
                end
                StArmed: begin
                    if (match) begin
                        state_d = StRinging;
                        cnt_d   = RingLoad;
                    end
                end
                StRinging: begin
                    if (stop_al) begin
                        state_d = StArmed;
                        cnt_d   = '0;
                    end else if (snooze) begin
                        state_d = StSnoozed;
                        cnt_d   = SnoozeLoad;
                    end else if (cnt_q <= CntOne) begin
                        state_d = StArmed;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end
                StSnoozed: begin
                    if (stop_al) begin
                        state_d = StArmed;
                        cnt_d   = '0;
                    end else if (cnt_q <= CntOne) begin
                        state_d = StRinging;
                        cnt_d   = RingLoad;
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end
                default: begin
                    state_d = StOff;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs
    always_comb begin
        ringing = (state_q == StRinging);
    end

endmodule

// File: rtl/multi_alarm_clock.sv
// 24-hour BCD time-of-day clock with NUM_ALARMS alarm channels.
// Holds the six BCD time digits, validates time/alarm loads, maps hours to
// 12-hour display format and encodes the lowest ringing channel.
// Ports:
//   clk_1s  1 Hz clock
//   reset   async active-high reset
//   bus     slave side of multi_alarm_clock_if (loads, controls, display,
//           alarm status, load_err)
module multi_alarm_clock
    import clock_pkg::*;
#(
    parameter int unsigned NUM_ALARMS     = 4,
    parameter int unsigned SNOOZE_S       = 300,
    parameter int unsigned RING_TIMEOUT_S = 60
) (
    input  logic                clk_1s,
    input  logic                reset,
    multi_alarm_clock_if.slave  bus
);

    localparam int unsigned IdW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

    tod_t                  time_q, time_d, time_inc;
    hhmm_t                 ld_val;
    logic                  ld_ok;
    logic                  load_err_q, load_err_d;
    logic                  tick_valid;
    logic                  alarm_load;
    logic [NUM_ALARMS-1:0] ring_vec;
    logic [IdW-1:0]        alarm_id;
    logic [4:0]            hour, hour12;
    logic [1:0]            h_disp1;
    logic [3:0]            h_disp0;
    logic                  pm;

    assign ld_val     = {bus.h_in1, bus.h_in0, bus.m_in1, bus.m_in0};
    assign ld_ok      = hhmm_valid(ld_val);
    assign tick_valid = !bus.ld_time;
    assign alarm_load = bus.ld_alarm && ld_ok;

    // One-second BCD increment with ripple carries, 23:59:59 -> 00:00:00.
    always_comb begin
        time_inc = time_q;
        if (time_q.s0 != DigitMax) begin
            time_inc.s0 = time_q.s0 + 4'd1;
        end else begin
            time_inc.s0 = 4'd0;
            if (time_q.s1 != Tens60Max) begin
                time_inc.s1 = time_q.s1 + 3'd1;
            end else begin
                time_inc.s1 = 3'd0;
                if (time_q.hm.m0 != DigitMax) begin
                    time_inc.hm.m0 = time_q.hm.m0 + 4'd1;
                end else begin
                    time_inc.hm.m0 = 4'd0;
                    if (time_q.hm.m1 != Tens60Max) begin
                        time_inc.hm.m1 = time_q.hm.m1 + 3'd1;
                    end else begin
                        time_inc.hm.m1 = 3'd0;
                        if ((time_q.hm.h1 == HourTensMax) &&
                            (time_q.hm.h0 == HourUnitsMaxAt2)) begin
                            time_inc.hm.h1 = 2'd0;
                            time_inc.hm.h0 = 4'd0;
                        end else if (time_q.hm.h0 == DigitMax) begin
                            time_inc.hm.h1 = time_q.hm.h1 + 2'd1;
                            time_inc.hm.h0 = 4'd0;
                        end else begin
                            time_inc.hm.h0 = time_q.hm.h0 + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // A time load pre-empts the increment; a rejected one holds the time.
    always_comb begin
        time_d     = time_inc;
        load_err_d = 1'b0;
        if (bus.ld_time) begin
            time_d = ld_ok ? {ld_val, 3'd0, 4'd0} : time_q;
        end
        if ((bus.ld_time || bus.ld_alarm) && !ld_ok) begin
            load_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset) begin
            time_q     <= '0;
            load_err_q <= 1'b0;
        end else begin
            time_q     <= time_d;
            load_err_q <= load_err_d;
        end
    end

    // Channels compare against time_d so they ring on the edge where the
    // display reaches HH:MM:00.
    for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_chan
        alarm_channel #(
            .SNOOZE_S       (SNOOZE_S),
            .RING_TIMEOUT_S (RING_TIMEOUT_S)
        ) u_chan (
            .clk_1s     (clk_1s),
            .reset      (reset),
            .next_time  (time_d),
            .tick_valid (tick_valid),
            .stop_al    (bus.stop_al),
            .snooze     (bus.snooze),
            .ld         (alarm_load && (bus.al_sel == IdW'(g))),
            .al_time_in (ld_val),
            .al_en_in   (bus.al_en_in),
            .ringing    (ring_vec[g])
        );
    end

    // Lowest-index ringing channel: scan downward so the last hit wins.
    always_comb begin
        alarm_id = '0;
        for (int i = int'(NUM_ALARMS) - 1; i >= 0; i--) begin
            if (ring_vec[i]) begin
                alarm_id = IdW'(i);
            end
        end
    end

    // 12-hour mapping: 00 -> 12 AM, 12 -> 12 PM, 13..23 -> 1..11 PM.
    always_comb begin
        hour    = hour_bin(time_q.hm.h1, time_q.hm.h0);
        hour12  = hour;
        pm      = 1'b0;
        h_disp1 = time_q.hm.h1;
        h_disp0 = time_q.hm.h0;
        if (bus.mode_12h) begin
            pm = (hour >= 5'd12);
            if (hour == 5'd0) begin
                hour12 = 5'd12;
            end else if (hour > 5'd12) begin
                hour12 = hour - 5'd12;
            end
            if (hour12 >= 5'd10) begin
                h_disp1 = 2'd1;
                h_disp0 = 4'(hour12 - 5'd10);
            end else begin
                h_disp1 = 2'd0;
                h_disp0 = hour12[3:0];
            end
        end
    end

    assign bus.h_out1   = h_disp1;
    assign bus.h_out0   = h_disp0;
    assign bus.m_out1   = time_q.hm.m1;
    assign bus.m_out0   = time_q.hm.m0;
    assign bus.s_out1   = time_q.s1;
    assign bus.s_out0   = time_q.s0;
    assign bus.pm       = pm;
    assign bus.alarm    = |ring_vec;
    assign bus.alarm_id = alarm_id;
    assign bus.ring_vec = ring_vec;
    assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_multi_alarm_clock.sv
module tb_multi_alarm_clock;

    localparam int unsigned NumAlarms = 4;

    logic clk_1s = 1'b0;
    logic reset  = 1'b1;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    multi_alarm_clock_if #(.NUM_ALARMS(NumAlarms)) bus ();

    multi_alarm_clock #(
        .NUM_ALARMS     (NumAlarms),
        .SNOOZE_S       (300),
        .RING_TIMEOUT_S (60)
    ) dut (
        .clk_1s (clk_1s),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_1s = ~clk_1s;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Display as hex nibbles HHMMSS.
    function automatic logic [31:0] disp_time();
        return {8'h00, 2'b00, bus.h_out1, bus.h_out0, 1'b0, bus.m_out1, bus.m_out0,
                1'b0, bus.s_out1, bus.s_out0};
    endfunction

    function automatic logic [31:0] disp_hour();
        return {24'h0, 2'b00, bus.h_out1, bus.h_out0};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk_1s);
        #1;
    endtask

    task automatic set_hm(input logic [1:0] h1, input logic [3:0] h0,
                          input logic [2:0] m1, input logic [3:0] m0);
        bus.h_in1 = h1;
        bus.h_in0 = h0;
        bus.m_in1 = m1;
        bus.m_in0 = m0;
    endtask

    task automatic load_time(input logic [1:0] h1, input logic [3:0] h0,
                             input logic [2:0] m1, input logic [3:0] m0);
        set_hm(h1, h0, m1, m0);
        bus.ld_time = 1'b1;
        tick(1);
        bus.ld_time = 1'b0;
    endtask

    task automatic load_alarm(input logic [1:0] sel, input logic en,
                              input logic [1:0] h1, input logic [3:0] h0,
                              input logic [2:0] m1, input logic [3:0] m0);
        set_hm(h1, h0, m1, m0);
        bus.al_sel   = sel;
        bus.al_en_in = en;
        bus.ld_alarm = 1'b1;
        tick(1);
        bus.ld_alarm = 1'b0;
    endtask

    initial begin
        set_hm(2'd0, 4'd0, 3'd0, 4'd0);
        bus.ld_time  = 1'b0;
        bus.ld_alarm = 1'b0;
        bus.al_sel   = '0;
        bus.al_en_in = 1'b0;
        bus.stop_al  = 1'b0;
        bus.snooze   = 1'b0;
        bus.mode_12h = 1'b0;

        // Reset state
        tick(2);
        check_eq("rst_time", disp_time(), 32'h00000000);
        check_eq("rst_alarm", 32'(bus.alarm), 32'd0);
        check_eq("rst_ring_vec", 32'(bus.ring_vec), 32'd0);
        check_eq("rst_alarm_id", 32'(bus.alarm_id), 32'd0);
        check_eq("rst_load_err", 32'(bus.load_err), 32'd0);
        check_eq("rst_pm", 32'(bus.pm), 32'd0);
        reset = 1'b0;

        // Midnight rollover
        load_time(2'd2, 4'd3, 3'd5, 4'd9);
        check_eq("ld_2359", disp_time(), 32'h00235900);
        check_eq("ld_2359_err", 32'(bus.load_err), 32'd0);
        tick(59);
        check_eq("t_235959", disp_time(), 32'h00235959);
        tick(1);
        check_eq("t_000000", disp_time(), 32'h00000000);
        check_eq("t_000000_err", 32'(bus.load_err), 32'd0);

        // Rejected loads hold the time
        load_time(2'd2, 4'd4, 3'd0, 4'd0);
        check_eq("rej_24_err", 32'(bus.load_err), 32'd1);
        check_eq("rej_24_time", disp_time(), 32'h00000000);
        load_time(2'd1, 4'd2, 3'd6, 4'd0);
        check_eq("rej_1260_err", 32'(bus.load_err), 32'd1);
        check_eq("rej_1260_time", disp_time(), 32'h00000000);
        tick(1);
        check_eq("err_clear", 32'(bus.load_err), 32'd0);
        check_eq("resume_time", disp_time(), 32'h00000001);
        load_alarm(2'd0, 1'b1, 2'd0, 4'd9, 3'd5, 4'd10);
        check_eq("rej_alarm_err", 32'(bus.load_err), 32'd1);
        check_eq("rej_alarm_time", disp_time(), 32'h00000002);

        // Channel 2 at 07:30, ring timeout 60
        load_alarm(2'd2, 1'b1, 2'd0, 4'd7, 3'd3, 4'd0);
        load_time(2'd0, 4'd7, 3'd2, 4'd9);
        check_eq("ld_0729", disp_time(), 32'h00072900);
        tick(59);
        check_eq("pre_ring_alarm", 32'(bus.alarm), 32'd0);
        tick(1);
        check_eq("ring_time", disp_time(), 32'h00073000);
        check_eq("ring_alarm", 32'(bus.alarm), 32'd1);
        check_eq("ring_id2", 32'(bus.alarm_id), 32'd2);
        check_eq("ring_vec2", 32'(bus.ring_vec), 32'h4);
        tick(59);
        check_eq("ring_last", 32'(bus.alarm), 32'd1);
        tick(1);
        check_eq("ring_timeout", 32'(bus.alarm), 32'd0);
        check_eq("timeout_time", disp_time(), 32'h00073100);

        // Channels 1 and 3 at 06:00, snooze then stop
        load_alarm(2'd1, 1'b1, 2'd0, 4'd6, 3'd0, 4'd0);
        load_alarm(2'd3, 1'b1, 2'd0, 4'd6, 3'd0, 4'd0);
        load_time(2'd0, 4'd5, 3'd5, 4'd9);
        tick(60);
        check_eq("dual_vec", 32'(bus.ring_vec), 32'hA);
        check_eq("dual_id", 32'(bus.alarm_id), 32'd1);
        bus.snooze = 1'b1;
        tick(1);
        bus.snooze = 1'b0;
        check_eq("snooze_silent", 32'(bus.alarm), 32'd0);
        tick(299);
        check_eq("snooze_end_silent", 32'(bus.ring_vec), 32'h0);
        tick(1);
        check_eq("rering_vec", 32'(bus.ring_vec), 32'hA);
        bus.stop_al = 1'b1;
        tick(1);
        bus.stop_al = 1'b0;
        check_eq("stop_alarm", 32'(bus.alarm), 32'd0);
        load_time(2'd0, 4'd5, 3'd5, 4'd9);
        tick(60);
        check_eq("rearmed_vec", 32'(bus.ring_vec), 32'hA);
        bus.stop_al = 1'b1;
        tick(1);
        bus.stop_al = 1'b0;
        check_eq("stop2_vec", 32'(bus.ring_vec), 32'h0);

        // 12-hour display
        bus.mode_12h = 1'b1;
        load_time(2'd0, 4'd0, 3'd1, 4'd5);
        check_eq("h12_0015", disp_hour(), 32'h12);
        check_eq("pm_0015", 32'(bus.pm), 32'd0);
        load_time(2'd1, 4'd2, 3'd0, 4'd0);
        check_eq("h12_1200", disp_hour(), 32'h12);
        check_eq("pm_1200", 32'(bus.pm), 32'd1);
        load_time(2'd1, 4'd3, 3'd4, 4'd5);
        check_eq("h12_1345", disp_hour(), 32'h01);
        check_eq("pm_1345", 32'(bus.pm), 32'd1);
        load_time(2'd2, 4'd3, 3'd1, 4'd0);
        check_eq("h12_2310", disp_hour(), 32'h11);
        check_eq("pm_2310", 32'(bus.pm), 32'd1);
        load_time(2'd0, 4'd9, 3'd0, 4'd0);
        check_eq("h12_0900", disp_hour(), 32'h09);
        check_eq("pm_0900", 32'(bus.pm), 32'd0);
        load_time(2'd1, 4'd3, 3'd4, 4'd5);
        bus.mode_12h = 1'b0;
        #1;
        check_eq("h24_1345", disp_hour(), 32'h13);
        check_eq("pm_24h", 32'(bus.pm), 32'd0);

        // Simultaneous time and alarm load; a time load never matches
        set_hm(2'd1, 4'd0, 3'd0, 4'd0);
        bus.al_sel   = 2'd0;
        bus.al_en_in = 1'b1;
        bus.ld_alarm = 1'b1;
        bus.ld_time  = 1'b1;
        tick(1);
        bus.ld_alarm = 1'b0;
        bus.ld_time  = 1'b0;
        check_eq("both_ld_time", disp_time(), 32'h00100000);
        check_eq("both_ld_nomatch", 32'(bus.alarm), 32'd0);

        // Reset while channel 0 rings
        load_time(2'd0, 4'd9, 3'd5, 4'd9);
        tick(60);
        check_eq("ch0_alarm", 32'(bus.alarm), 32'd1);
        check_eq("ch0_id", 32'(bus.alarm_id), 32'd0);
        check_eq("ch0_vec", 32'(bus.ring_vec), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_rst_alarm", 32'(bus.alarm), 32'd0);
        check_eq("async_rst_vec", 32'(bus.ring_vec), 32'h0);
        check_eq("async_rst_time", disp_time(), 32'h00000000);
        #1;
        reset = 1'b0;
        load_time(2'd0, 4'd5, 3'd5, 4'd9);
        tick(60);
        check_eq("post_rst_time", disp_time(), 32'h00060000);
        check_eq("post_rst_off", 32'(bus.ring_vec), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_alarm_clock.md
# multi_alarm_clock

24-hour BCD time-of-day counter with `NUM_ALARMS` independently programmable alarm channels, per-channel snooze and ring timeout, and a 12/24-hour display mode. It runs on the 1 Hz tick domain and feeds the display and buzzer drivers. Time is held directly in BCD digit registers, so there is no binary-to-BCD conversion.

## Interface
- `NUM_ALARMS`, 4: number of alarm channels (1–8).
- `SNOOZE_S`, 300: snooze duration in seconds.
- `RING_TIMEOUT_S`, 60: seconds a channel rings before it re-arms automatically.
- `clk_1s`  in  1  clock. Asynchronous, active-high reset `reset`; clock `clk_1s`.
- `reset`  in  1  async active-high reset.
- `h_in1 [1:0]`, `h_in0 [3:0]`, `m_in1 [2:0]`, `m_in0 [3:0]`  in  BCD load value, always 24-hour.
- `ld_time`  in  1  load the current time from the BCD inputs; seconds are set to 00.
- `ld_alarm`  in  1  load the alarm time into channel `al_sel`.
- `al_sel`  in  $clog2(NUM_ALARMS) (min 1)  target channel for `ld_alarm`.
- `al_en_in`  in  1  enable written with `ld_alarm`.
- `stop_al`  in  1  silence all ringing and snoozed channels.
- `snooze`  in  1  snooze all ringing channels.
- `mode_12h`  in  1  select 12-hour display format.
- `h_out1 [1:0]`, `h_out0 [3:0]`, `m_out1 [2:0]`, `m_out0 [3:0]`, `s_out1 [2:0]`, `s_out0 [3:0]`  out  BCD display digits.
- `pm`  out  1  PM indicator; 0 when `mode_12h`=0.
- `alarm`  out  1  OR of all ringing channels.
- `alarm_id`  out  $clog2(NUM_ALARMS)  lowest-index ringing channel; 0 when none.
- `ring_vec`  out  NUM_ALARMS  per-channel ringing flags.
- `load_err`  out  1  one-cycle pulse when a load is rejected.

## Operation
- Time registers: six BCD digits. Each `clk_1s` cycle advances time by 1 s with BCD carries.
  - 59 s wraps to 00 and carries into minutes; 59 min carries into hours.
  - 23:59:59 wraps to 00:00:00.
- Load validation: a load is rejected if hour > 23, minute > 59, any digit > 9, or `h_in1` = 3.
  - A rejected load changes no register and pulses `load_err`.
- `ld_time` has priority over increment. A time load never triggers an alarm match.
- `ld_alarm` writes HH:MM and the enable to the selected channel, and forces that channel to ARMED (enable=1) or OFF (enable=0).
- `ld_time` and `ld_alarm` in the same cycle are both honoured.
- Channel FSM:
  - OFF: no transitions except via `ld_alarm`.
  - ARMED → RINGING: the next-time value equals the channel's HH:MM:00 and no `ld_time` is active. The ring counter loads `RING_TIMEOUT_S`.
  - RINGING → SNOOZED: `snooze`=1. The snooze counter loads `SNOOZE_S`.
  - RINGING → ARMED: `stop_al`=1, or the ring counter reaches 0.
  - SNOOZED → RINGING: the snooze counter reaches 0. The ring counter reloads.
  - SNOOZED → ARMED: `stop_al`=1.
- Priority per channel: `ld_alarm` to that channel > `stop_al` > `snooze` > timers > match.
- Several channels may match the same minute; all of them ring.
- 12-hour display:
  - Hour 00 shows 12 with `pm`=0; 01–11 show unchanged with `pm`=0.
  - Hour 12 shows 12 with `pm`=1; 13–23 show hour−12 with `pm`=1.
  - Display mapping is combinational from the hour registers.
- Reset values:
  - Time 00:00:00; all channels OFF with alarm times 00:00.
  - `alarm`=0, `ring_vec`=0, `alarm_id`=0, `load_err`=0, `pm`=0.
  - Counters cleared. A reset mid-ring silences immediately (asynchronously).

## Timing
- All state updates on the rising edge of `clk_1s`; inputs are sampled on that edge.
- Load latency: 1 cycle. Display shows the loaded time after the edge that samples `ld_time`.
- Ring onset: `alarm` rises on the same edge at which the display reaches the alarm HH:MM:00.
- `stop_al` or `snooze`: `alarm` falls on the sampling edge.
- Ring timeout: rings exactly `RING_TIMEOUT_S` cycles, then falls.
- Snooze: silent exactly `SNOOZE_S` cycles, then re-rings.
- Counter widths: `$clog2(max(SNOOZE_S, RING_TIMEOUT_S)+1)`.
- `alarm`, `ring_vec`, and `alarm_id` are registered or derived only from registered state; no combinational path from inputs.

## Structure
- Package `clock_pkg`:
  - Channel state enum (OFF, ARMED, RINGING, SNOOZED).
  - BCD digit limit constants.
  - Packed struct for HH:MM alarm time.
- Sub-module `alarm_channel`, instanced `NUM_ALARMS` times:
  - Contains the alarm time register, FSM, and ring/snooze counter.
  - Inputs: `next_time`, `tick_valid` (no `ld_time`), `stop_al`, `snooze`, and its load strobe.
- Top level holds the BCD time counter, load validation, 12-hour mapping, and the priority encoder for `alarm_id`.

## Test plan
- Load 23:59 via `ld_time`, run 60 cycles → display passes 23:59:59 then 00:00:00; no `load_err`.
- Load time 24:00, then 12:60 → `load_err` pulses both times; time unchanged.
- Channel 2 armed at 07:30, time loaded 07:29, run 60 cycles → `alarm`=1 and `alarm_id`=2 on the edge showing 07:30:00; falls after 60 cycles (`RING_TIMEOUT_S`=60).
- Channels 1 and 3 both at 06:00; ring, then `snooze` → both silent for 300 cycles, then re-ring; `stop_al` → both ARMED, `alarm`=0.
- `mode_12h`=1 with time 00:15, 12:00, 13:45 → `h_out` = 12/12/01, `pm` = 0/1/1.
- Assert `reset` while channel 0 is ringing → `alarm`=0 immediately; time 00:00:00; all channels OFF.
